muldiv_unit: RTL and testbench

- Parametrised iterative multiply/divide unit for the EX stage of the pipelined MIPS core; successor to the shift-add multiplier.
- Executes MULT, MULTU, DIV and DIVU with its own internal WIDTH-bit adder/subtractor, so it no longer borrows the pipeline ALU.
- Owns the HI/LO architectural registers, supports MTHI/MTLO writes, and exposes a start/busy/done handshake so hazard logic can stall MFHI/MFLO.

---
 rtl/muldiv_pkg.sv | 20 ++
 rtl/muldiv_if.sv | 26 ++
 rtl/muldiv_addsub.sv | 16 +
 rtl/muldiv_unit.sv | 140 ++++++++++++++
 tb/tb_muldiv_unit.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encoding,
// FSM states and op-decoding helpers.
package muldiv_pkg;

   localparam logic [1:0] OP_MULTU = 2'b00;
   localparam logic [1:0] OP_MULT  = 2'b01;
   localparam logic [1:0] OP_DIVU  = 2'b10;
   localparam logic [1:0] OP_DIV   = 2'b11;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

   function automatic logic op_is_div(input logic [1:0] op);
      return (op == OP_DIVU) || (op == OP_DIV);
   endfunction

   function automatic logic op_is_signed(input logic [1:0] op);
      return (op == OP_MULT) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/muldiv_if.sv
// Handshake, operand and HI/LO bus between the EX stage and the mul/div unit.
interface muldiv_if #(parameter int WIDTH = 32);
   logic             i_start;
   logic [1:0]       i_op;
   logic [WIDTH-1:0] i_src_a;
   logic [WIDTH-1:0] i_src_b;
   logic             i_flush;
   logic             i_hi_we;
   logic             i_lo_we;
   logic [WIDTH-1:0] i_wdata;
   logic             o_busy;
   logic             o_done;
   logic             o_div_zero;
   logic [WIDTH-1:0] o_hi;
   logic [WIDTH-1:0] o_lo;

   modport master (
      output i_start, i_op, i_src_a, i_src_b, i_flush, i_hi_we, i_lo_we, i_wdata,
      input  o_busy, o_done, o_div_zero, o_hi, o_lo
   );

   modport slave (
      input  i_start, i_op, i_src_a, i_src_b, i_flush, i_hi_we, i_lo_we, i_wdata,
      output o_busy, o_done, o_div_zero, o_hi, o_lo
   );
endinterface

// File: rtl/muldiv_addsub.sv
// Combinational (WIDTH+1)-bit adder/subtractor shared by shift-add multiply
// and restoring divide. For subtraction, o_carry=1 means i_a >= i_b.
module muldiv_addsub #(parameter int WIDTH = 32) (
   input  logic [WIDTH:0] i_a,
   input  logic [WIDTH:0] i_b,
   input  logic           i_sub,
   output logic [WIDTH:0] o_sum,
   output logic           o_carry
);
   logic [WIDTH+1:0] w_full;

   assign w_full  = {1'b0, i_a} + {1'b0, i_b ^ {(WIDTH+1){i_sub}}}
                  + {{(WIDTH+1){1'b0}}, i_sub};
   assign o_sum   = w_full[WIDTH:0];
   assign o_carry = w_full[WIDTH+1];
endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU unit owning HI/LO. Operates on
// magnitudes during RUN and applies signs in a single FIX cycle.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic     clk,
   input  logic     rst,
   muldiv_if.slave  bus
);
   localparam int CNT_W = $clog2(WIDTH + 1);

   state_t             r_state, w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_opd, r_a_raw, r_hi, r_lo;
   logic               r_div, r_neg_res, r_neg_rem, r_dz;

   logic               w_start_ok, w_last, w_sgn, w_is_div, w_dz;
   logic [WIDTH-1:0]   w_abs_a, w_abs_b;
   logic [WIDTH:0]     w_add_a, w_add_b, w_sum;
   logic               w_carry;
   logic [2*WIDTH-1:0] w_step, w_prod;
   logic [WIDTH-1:0]   w_fix_hi, w_fix_lo;

   // Flush only blocks a launch from IDLE; a back-to-back start in DONE always goes.
   assign w_start_ok = bus.i_start &&
                       (((r_state == S_IDLE) && !bus.i_flush) || (r_state == S_DONE));
   assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
   assign w_sgn      = op_is_signed(bus.i_op);
   assign w_is_div   = op_is_div(bus.i_op);
   assign w_abs_a    = (w_sgn && bus.i_src_a[WIDTH-1]) ? -bus.i_src_a : bus.i_src_a;
   assign w_abs_b    = (w_sgn && bus.i_src_b[WIDTH-1]) ? -bus.i_src_b : bus.i_src_b;
   assign w_dz       = r_div && (r_opd == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_start_ok) w_state_nxt = S_RUN;
         S_RUN:   if (bus.i_flush) w_state_nxt = S_IDLE;
                  else if (w_last) w_state_nxt = S_FIX;
         S_FIX:   w_state_nxt = bus.i_flush ? S_IDLE : S_DONE;
         S_DONE:  w_state_nxt = w_start_ok ? S_RUN : S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Divide: trial-subtract divisor from {R, next dividend bit}.
   // Multiply: add multiplicand into the upper half when the LSB is set.
   always_comb begin
      if (r_div) begin
         w_add_a = r_acc[2*WIDTH-1:WIDTH-1];
         w_add_b = {1'b0, r_opd};
      end else begin
         w_add_a = {1'b0, r_acc[2*WIDTH-1:WIDTH]};
         w_add_b = {1'b0, r_opd & {WIDTH{r_acc[0]}}};
      end
   end

   muldiv_addsub #(.WIDTH(WIDTH)) u_addsub (
      .i_a     (w_add_a),
      .i_b     (w_add_b),
      .i_sub   (r_div),
      .o_sum   (w_sum),
      .o_carry (w_carry)
   );

   always_comb begin
      if (r_div)
         w_step = w_carry ? {w_sum[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1}
                          : {r_acc[2*WIDTH-2:0], 1'b0};
      else
         w_step = {w_sum, r_acc[WIDTH-1:1]};
   end

   assign w_prod = r_neg_res ? -r_acc : r_acc;

   always_comb begin
      w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
      w_fix_lo = w_prod[WIDTH-1:0];
      if (w_dz) begin
         w_fix_hi = r_a_raw;
         w_fix_lo = '1;
      end else if (r_div) begin
         w_fix_hi = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
         w_fix_lo = r_neg_res ? -r_acc[WIDTH-1:0]       : r_acc[WIDTH-1:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt     <= '0;
         r_acc     <= '0;
         r_opd     <= '0;
         r_a_raw   <= '0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_div     <= 1'b0;
         r_neg_res <= 1'b0;
         r_neg_rem <= 1'b0;
         r_dz      <= 1'b0;
      end else begin
         if (r_state == S_IDLE) begin
            if (bus.i_hi_we) r_hi <= bus.i_wdata;
            if (bus.i_lo_we) r_lo <= bus.i_wdata;
         end
         if (w_start_ok) begin
            r_cnt     <= '0;
            r_div     <= w_is_div;
            r_acc     <= {{WIDTH{1'b0}}, w_is_div ? w_abs_a : w_abs_b};
            r_opd     <= w_is_div ? w_abs_b : w_abs_a;
            r_a_raw   <= bus.i_src_a;
            r_neg_res <= w_sgn && (bus.i_src_a[WIDTH-1] ^ bus.i_src_b[WIDTH-1]);
            r_neg_rem <= w_sgn && bus.i_src_a[WIDTH-1];
            r_dz      <= 1'b0;
         end else if (r_state == S_RUN) begin
            r_acc <= w_step;
            r_cnt <= r_cnt + 1'b1;
         end
         if ((r_state == S_FIX) && !bus.i_flush) begin
            r_hi <= w_fix_hi;
            r_lo <= w_fix_lo;
            if (w_dz) r_dz <= 1'b1;
         end
      end
   end

   assign bus.o_busy     = (r_state == S_RUN) || (r_state == S_FIX);
   assign bus.o_done     = (r_state == S_DONE);
   assign bus.o_div_zero = r_dz;
   assign bus.o_hi       = r_hi;
   assign bus.o_lo       = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized self-checking bench for muldiv_unit against a plain-arithmetic
// reference of MULT/MULTU/DIV/DIVU plus directed handshake corner cases.
module tb_muldiv_unit;
   localparam int W = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   muldiv_if #(.WIDTH(W)) bus();
   muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

   int n_tot = 0;
   int n_bad = 0;
   int lat, bcnt, dcnt;
   logic dz1;
   logic [31:0] exp_hi, exp_lo;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // {div_zero, hi, lo}
   function automatic logic [64:0] ref_md(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (op == 2'd0) p = {32'h0, a} * {32'h0, b};
      else if (op == 2'd1) p = sa * sb;
      else if (b == 32'h0) return {1'b1, a, 32'hFFFF_FFFF};
      else if (op == 2'd2) p = {a % b, a / b};
      else begin
         q = sa / sb;
         r = sa % sb;
         p = {r[31:0], q[31:0]};
      end
      return {1'b0, p};
   endfunction

   task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit now);
      if (!now) @(negedge clk);
      bus.i_start = 1'b1; bus.i_op = op; bus.i_src_a = a; bus.i_src_b = b;
      @(posedge clk); #1;
      bus.i_start = 1'b0; bus.i_op = 2'($urandom);
      bus.i_src_a = $urandom; bus.i_src_b = $urandom;
      lat = 0; bcnt = 0;
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         if (c == 1) dz1 = bus.o_div_zero;
         if (bus.o_busy) bcnt++;
         if (bus.o_done) begin lat = c; break; end
      end
   endtask

   task automatic check_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input bit now);
      logic [64:0] e;
      e = ref_md(op, a, b);
      do_op(op, a, b, now);
      chk({tag, ".lat"}, lat, 34);
      chk({tag, ".hi"}, bus.o_hi, e[63:32]);
      chk({tag, ".lo"}, bus.o_lo, e[31:0]);
      chk({tag, ".dz"}, bus.o_div_zero, e[64]);
      exp_hi = e[63:32];
      exp_lo = e[31:0];
   endtask

   initial begin
      bus.i_start = 0; bus.i_op = 0; bus.i_src_a = 0; bus.i_src_b = 0;
      bus.i_flush = 0; bus.i_hi_we = 0; bus.i_lo_we = 0; bus.i_wdata = 0;
      repeat (2) @(negedge clk);
      chk("rst.hi", bus.o_hi, 0);
      chk("rst.lo", bus.o_lo, 0);
      chk("rst.busy", bus.o_busy, 0);
      chk("rst.done", bus.o_done, 0);
      chk("rst.dz", bus.o_div_zero, 0);
      rst = 1'b0;

      check_op("multu_max", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      chk("multu_max.busy_cycles", bcnt, 33);
      chk("multu_max.hi_k", bus.o_hi, 32'hFFFF_FFFE);
      chk("multu_max.lo_k", bus.o_lo, 32'h0000_0001);
      check_op("mult_n3x7", 2'd1, 32'hFFFF_FFFD, 32'd7, 0);
      chk("mult_n3x7.lo_k", bus.o_lo, 32'hFFFF_FFEB);
      check_op("mult_n3xn7", 2'd1, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 1);
      chk("mult_n3xn7.lo_k", bus.o_lo, 32'd21);
      check_op("div_n7d2", 2'd3, 32'hFFFF_FFF9, 32'd2, 0);
      chk("div_n7d2.hi_k", bus.o_hi, 32'hFFFF_FFFF);
      chk("div_n7d2.lo_k", bus.o_lo, 32'hFFFF_FFFD);
      check_op("divu_100d7", 2'd2, 32'd100, 32'd7, 1);
      chk("divu_100d7.lo_k", bus.o_lo, 32'd14);
      check_op("divu_z", 2'd2, 32'h1234, 32'h0, 0);
      chk("divu_z.dz_k", bus.o_div_zero, 1);
      chk("divu_z.hi_k", bus.o_hi, 32'h1234);
      check_op("multu_after_z", 2'd0, 32'd3, 32'd4, 0);
      chk("dz_cleared_by_start", dz1, 0);
      check_op("div_min_m1", 2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1);
      chk("div_min_m1.lo_k", bus.o_lo, 32'h8000_0000);
      check_op("div_z_neg", 2'd3, 32'hFFFF_FF00, 32'h0, 1);

      // flush mid-run: no done, HI/LO untouched
      @(negedge clk);
      bus.i_start = 1; bus.i_op = 2'd0; bus.i_src_a = 5; bus.i_src_b = 6;
      @(posedge clk); #1 bus.i_start = 0;
      repeat (10) @(negedge clk);
      bus.i_flush = 1;
      @(posedge clk); #1 bus.i_flush = 0;
      dcnt = 0;
      @(negedge clk);
      chk("flush.busy", bus.o_busy, 0);
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (bus.o_done) dcnt++;
      end
      chk("flush.no_done", dcnt, 0);
      chk("flush.hi", bus.o_hi, exp_hi);
      chk("flush.lo", bus.o_lo, exp_lo);
      check_op("after_flush", 2'd0, 32'd2, 32'd3, 0);
      chk("after_flush.lo_k", bus.o_lo, 32'd6);

      // flush beats start in IDLE
      @(negedge clk);
      bus.i_start = 1; bus.i_flush = 1; bus.i_op = 2'd0;
      @(posedge clk); #1 bus.i_start = 0; bus.i_flush = 0;
      @(negedge clk);
      chk("flush_start.busy", bus.o_busy, 0);

      // MTLO and extra start while busy are both dropped
      @(negedge clk);
      bus.i_start = 1; bus.i_op = 2'd2; bus.i_src_a = 1000; bus.i_src_b = 3;
      @(posedge clk); #1 bus.i_start = 0;
      repeat (5) @(negedge clk);
      bus.i_lo_we = 1; bus.i_wdata = 32'hA5; bus.i_start = 1; bus.i_op = 2'd0;
      @(posedge clk); #1 bus.i_lo_we = 0; bus.i_start = 0;
      dcnt = 0;
      for (int c = 0; c < 80; c++) begin
         @(negedge clk);
         if (bus.o_done) begin
            dcnt++;
            if (dcnt == 1) begin
               chk("busy_we.lo", bus.o_lo, 32'd333);
               chk("busy_we.hi", bus.o_hi, 32'd1);
            end
         end
      end
      chk("busy_start.done_count", dcnt, 1);

      @(negedge clk);
      bus.i_lo_we = 1; bus.i_wdata = 32'hA5;
      @(posedge clk); #1 bus.i_lo_we = 0;
      @(negedge clk);
      chk("idle_mtlo", bus.o_lo, 32'hA5);
      bus.i_hi_we = 1; bus.i_wdata = 32'h5A;
      @(posedge clk); #1 bus.i_hi_we = 0;
      @(negedge clk);
      chk("idle_mthi", bus.o_hi, 32'h5A);
      chk("idle_mthi.lo_kept", bus.o_lo, 32'hA5);

      // MTHI together with an accepted start
      bus.i_hi_we = 1; bus.i_wdata = 32'h77; bus.i_start = 1;
      bus.i_op = 2'd0; bus.i_src_a = 2; bus.i_src_b = 2;
      @(posedge clk); #1 bus.i_hi_we = 0; bus.i_start = 0;
      @(negedge clk);
      chk("mthi_start.hi", bus.o_hi, 32'h77);
      chk("mthi_start.busy", bus.o_busy, 1);
      dcnt = 0;
      for (int c = 2; c <= 60; c++) begin
         @(negedge clk);
         if (bus.o_done) begin dcnt = c; break; end
      end
      chk("mthi_start.lat", dcnt, 34);
      chk("mthi_start.lo", bus.o_lo, 32'd4);

      // async reset mid-operation
      @(negedge clk);
      bus.i_start = 1; bus.i_op = 2'd1; bus.i_src_a = 9; bus.i_src_b = 9;
      @(posedge clk); #1 bus.i_start = 0;
      repeat (5) @(negedge clk);
      #1 rst = 1;
      #1;
      chk("rst_mid.busy", bus.o_busy, 0);
      chk("rst_mid.hi", bus.o_hi, 0);
      chk("rst_mid.lo", bus.o_lo, 0);
      @(negedge clk) rst = 0;

      for (int i = 0; i < 40; i++) begin
         logic [31:0] a, b;
         logic [1:0] op;
         op = 2'($urandom);
         case ($urandom_range(0, 5))
            0: a = 32'h8000_0000;
            1: a = 32'hFFFF_FFFF;
            default: a = $urandom;
         endcase
         case ($urandom_range(0, 5))
            0: b = 32'h0;
            1: b = 32'hFFFF_FFFF;
            2: b = $urandom_range(1, 15);
            default: b = $urandom;
         endcase
         check_op($sformatf("rnd%0d", i), op, a, b, 1'($urandom_range(0, 1)));
      end

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end
endmodule
